// File: rtl/fpcvt_pkg.sv
// Shared types, widths and helpers for the serial 13-bit to 9-bit float converter.
// The optional saturation counter is enabled with FPCVT_CTRL_STATS_EN.
package fpcvt_pkg;

  localparam int D_W   = 13;
  localparam int MAG_W = 12;
  localparam int E_W   = 3;
  localparam int F_W   = 5;

  localparam logic [E_W-1:0] EXP_MAX = 3'd7;
  localparam logic [F_W-1:0] F_MAX   = 5'b11111;
  localparam logic [D_W-1:0] D_MIN   = 13'h1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_HOLD  = 2'd3
  } fpcvt_state_t;

  // Magnitude of a two's-complement sample; the most negative code clamps to all ones.
  function automatic logic [MAG_W-1:0] abs_clamp(input logic [D_W-1:0] d);
    logic [D_W-1:0] neg;
    neg = (~d) + 13'd1;
    if (d == D_MIN) begin
      abs_clamp = 12'hFFF;
    end else if (d[D_W-1]) begin
      abs_clamp = neg[MAG_W-1:0];
    end else begin
      abs_clamp = d[MAG_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fpcvt_seq_ctrl_round.sv
// Round-to-nearest (half up) of the normalised magnitude into the 5-bit significand.
// Carry out of the significand bumps the exponent, or saturates at the top exponent.
module fpcvt_seq_ctrl_round
  import fpcvt_pkg::*;
(
  input  logic [5:0]     mag_hi,
  input  logic [E_W-1:0] exp,
  output logic [F_W-1:0] f,
  output logic [E_W-1:0] e,
  output logic           ovf
);

  logic [F_W-1:0] f_raw_s;
  logic           r_s;

  assign f_raw_s = mag_hi[5:1];
  assign r_s     = mag_hi[0];

  // Rounding decision with exponent carry and top-of-range saturation.
  always_comb begin
    f   = f_raw_s;
    e   = exp;
    ovf = 1'b0;
    if (r_s) begin
      if (f_raw_s != F_MAX) begin
        f = f_raw_s + 5'd1;
      end else if (exp != EXP_MAX) begin
        f = 5'b10000;
        e = exp + 3'd1;
      end else begin
        f   = F_MAX;
        e   = EXP_MAX;
        ovf = 1'b1;
      end
    end else begin
      f = f_raw_s;
    end
  end

endmodule

// File: rtl/fpcvt_seq_ctrl.sv
// Sequencer for the serial 13-bit two's-complement to S/E3/F5 float conversion.
// Defining FPCVT_CTRL_STATS_EN adds the sat_count saturation-event counter.
module fpcvt_seq_ctrl
  import fpcvt_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [D_W-1:0] in_d,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_s,
  output logic [E_W-1:0] out_e,
`ifdef FPCVT_CTRL_STATS_EN
  output logic [F_W-1:0] out_f,
  output logic [7:0]     sat_count
`else
  output logic [F_W-1:0] out_f
`endif
);

  fpcvt_state_t   state_r, state_s;
  logic [MAG_W-1:0] mag_r;
  logic [E_W-1:0] exp_r;
  logic           sign_r;
  logic           accept_s;
  logic           norm_done_s;
  logic [F_W-1:0] rnd_f_s;
  logic [E_W-1:0] rnd_e_s;
  logic           rnd_ovf_s;

  // Gated by rst_n so the port reads 0 while reset is held and 1 right after release.
  assign in_ready    = rst_n & (state_r == ST_IDLE);
  assign accept_s    = in_valid & in_ready;
  assign norm_done_s = mag_r[MAG_W-1] | (exp_r == 3'd0);

  fpcvt_seq_ctrl_round u_round (
    .mag_hi (mag_r[MAG_W-1:MAG_W-6]),
    .exp    (exp_r),
    .f      (rnd_f_s),
    .e      (rnd_e_s),
    .ovf    (rnd_ovf_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_NORM;
        else          state_s = ST_IDLE;
      end
      ST_NORM: begin
        if (norm_done_s) state_s = ST_ROUND;
        else             state_s = ST_NORM;
      end
      ST_ROUND: state_s = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) state_s = ST_IDLE;
        else           state_s = ST_HOLD;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Shared magnitude/exponent datapath, normalised one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_r  <= 12'd0;
      exp_r  <= 3'd0;
      sign_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            sign_r <= in_d[D_W-1];
            mag_r  <= abs_clamp(in_d);
            exp_r  <= EXP_MAX;
          end
        end
        ST_NORM: begin
          if (!norm_done_s) begin
            mag_r <= {mag_r[MAG_W-2:0], 1'b0};
            exp_r <= exp_r - 3'd1;
          end
        end
        default: begin
          mag_r <= mag_r;
        end
      endcase
    end
  end

  // Result registers: loaded only on ROUND->HOLD, held until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= 3'd0;
      out_f     <= 5'd0;
    end else begin
      case (state_r)
        ST_ROUND: begin
          out_valid <= 1'b1;
          out_s     <= sign_r;
          out_e     <= rnd_e_s;
          out_f     <= rnd_f_s;
        end
        ST_HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FPCVT_CTRL_STATS_EN
  logic sat_r;

  // Saturation flag and event counter; the counter sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_r     <= 1'b0;
      sat_count <= 8'd0;
    end else begin
      if (accept_s) begin
        sat_r <= (in_d == D_MIN);
      end
      if ((state_r == ST_ROUND) && (sat_r || rnd_ovf_s) && (sat_count != 8'hFF)) begin
        sat_count <= sat_count + 8'd1;
      end
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = rnd_ovf_s;
`endif

endmodule

// File: tb/tb_fpcvt_seq_ctrl.sv
// Directed bench for fpcvt_seq_ctrl: conversions, latency, back-pressure and mid-run reset.
// Expected values are hand-derived from the conversion rules.
module tb_fpcvt_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [12:0] in_d;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [4:0]  out_f;
`ifdef FPCVT_CTRL_STATS_EN
  logic [7:0]  sat_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  fpcvt_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_d      (in_d),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
`ifdef FPCVT_CTRL_STATS_EN
    .out_f     (out_f),
    .sat_count (sat_count)
`else
    .out_f     (out_f)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic wait_valid(input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic check_res(input string tag, input logic s, input logic [2:0] e, input logic [4:0] f);
    check_val({tag, "_s"}, {31'd0, out_s}, {31'd0, s});
    check_val({tag, "_e"}, {29'd0, out_e}, {29'd0, e});
    check_val({tag, "_f"}, {27'd0, out_f}, {27'd0, f});
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic convert(input logic [12:0] d, input logic s, input logic [2:0] e,
                         input logic [4:0] f, input int lat, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_d     = d;
    check_val({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat, tag);
    check_res(tag, s, e, f);
    take(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_d      = 13'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_rdy", {31'd0, in_ready}, 32'd0);
    check_val("rst_vld", {31'd0, out_valid}, 32'd0);
    check_res("rst", 1'b0, 3'd0, 5'd0);
`ifdef FPCVT_CTRL_STATS_EN
    check_val("rst_satcnt", {24'd0, sat_count}, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check_val("rel_rdy", {31'd0, in_ready}, 32'd1);

    convert(13'd55,    1'b0, 3'b001, 5'b11100, 8, "d55");
    convert(13'd1008,  1'b0, 3'b110, 5'b10000, 4, "d1008");
    convert(13'd4,     1'b0, 3'b000, 5'b00100, 9, "d4");
    convert(13'd0,     1'b0, 3'b000, 5'b00000, 9, "zero");
    convert(13'h1000,  1'b1, 3'b111, 5'b11111, 2, "m4096");
    convert(13'd4095,  1'b0, 3'b111, 5'b11111, 2, "d4095");
    convert(13'h1FC9,  1'b1, 3'b001, 5'b11100, 8, "m55");
`ifdef FPCVT_CTRL_STATS_EN
    check_val("satcnt2", {24'd0, sat_count}, 32'd2);
`endif

    // Back-pressure: result for 55 held while 1008 waits at the input.
    @(negedge clk);
    in_valid = 1'b1;
    in_d     = 13'd55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(8, "bp55");
    @(negedge clk);
    in_valid = 1'b1;
    in_d     = 13'd1008;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("bp_rdy", {31'd0, in_ready}, 32'd0);
      check_val("bp_vld", {31'd0, out_valid}, 32'd1);
      check_res("bp_hold", 1'b0, 3'b001, 5'b11100);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("bp_drop", {31'd0, out_valid}, 32'd0);
    check_val("bp_idle_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("bp_accept", {31'd0, in_ready}, 32'd0);
    wait_valid(4, "bp1008");
    check_res("bp1008", 1'b0, 3'b110, 5'b10000);
    take("bp1008");

    // Reset in the middle of normalisation.
    @(negedge clk);
    in_valid = 1'b1;
    in_d     = 13'd253;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mr_rdy", {31'd0, in_ready}, 32'd0);
    check_val("mr_vld", {31'd0, out_valid}, 32'd0);
    check_res("mr", 1'b0, 3'd0, 5'd0);
`ifdef FPCVT_CTRL_STATS_EN
    check_val("mr_satcnt", {24'd0, sat_count}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("mr_rel_rdy", {31'd0, in_ready}, 32'd1);
    check_val("mr_rel_vld", {31'd0, out_valid}, 32'd0);
    convert(13'd253, 1'b0, 3'b100, 5'b10000, 6, "d253");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
